// File: rtl/if_id_queue_pkg.sv
// -----------------------------------------------------------------------------
// if_id_queue_pkg
//   Shared constants for the IF/ID fetch queue and the pipeline controller.
//
//   Stall-bit encoding: the controller drives one stall bit per pipeline stage.
//   Stop (1) freezes that stage and NoStop (0) lets it advance. The IF/ID queue
//   reads its own bit (stall[STAGE]) and the next stage's bit (stall[STAGE+1])
//   with exactly the same encoding the controller uses, so any change here must
//   be mirrored in the controller.
//
//   IfqCntBus(depth) gives the width of an occupancy counter able to hold
//   0..depth inclusive.
// -----------------------------------------------------------------------------
`ifndef IfqCntBus
`define IfqCntBus(depth) ($clog2((depth) + 1))
`endif

package if_id_queue_pkg;

  localparam logic [31:0] ZeroWord  = 32'h0000_0000;
  localparam logic        RstEnable = 1'b1;

  // Stall-vector bit values, shared with the pipeline controller.
  localparam logic        Stop      = 1'b1;
  localparam logic        NoStop    = 1'b0;

endpackage : if_id_queue_pkg

// File: rtl/if_id_queue_mem.sv
// -----------------------------------------------------------------------------
// ifq_mem
//   DEPTH x WIDTH storage array for the IF/ID fetch queue.
//   Synchronous write port, asynchronous read of the head entry so the output
//   register can load it in the same cycle it is popped. Contents are not reset:
//   occupancy is tracked by the owning queue, so stale entries are never read.
//
//   Ports:
//     clk    in   clock
//     we     in   write enable
//     waddr  in   write address (tail pointer)
//     wdata  in   write data {pc, inst}
//     raddr  in   read address (head pointer)
//     rdata  out  head entry
// -----------------------------------------------------------------------------
module ifq_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule : ifq_mem

// File: rtl/if_id_queue.sv
// -----------------------------------------------------------------------------
// if_id_queue
//   IF/ID pipeline register with a DEPTH-entry fetch queue in front of it.
//   Fetched instructions are buffered while ID is stalled instead of being
//   re-fetched. The ID-facing outputs are registered; with an empty queue and
//   no stall an incoming instruction bypasses the array, giving one cycle of
//   latency exactly like a plain IF/ID register.
//
//   Ports:
//     clk, rst           clock, synchronous active-high reset
//     if_valid/pc/inst   fetched instruction from IF
//     stall              controller stall vector (1 = Stop)
//     flush              exception/redirect flush, empties the queue
//     if_full            registered queue-full stall request to the controller
//     q_count            registered queue occupancy
//     id_pc/inst/valid   registered instruction presented to ID (valid=0: bubble)
//     occ_max            high-water mark of q_count (only with IFQ_OCC_MAX_EN)
//
//   Optional feature macro: IFQ_OCC_MAX_EN adds the occ_max port and logic.
// -----------------------------------------------------------------------------
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int INST_W  = 32,
  parameter int DEPTH   = 4,
  parameter int STALL_W = 6,
  parameter int STAGE   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       if_valid,
  input  logic [ADDR_W-1:0]          if_pc,
  input  logic [INST_W-1:0]          if_inst,
  input  logic [STALL_W-1:0]         stall,
  input  logic                       flush,
  output logic                       if_full,
  output logic [$clog2(DEPTH+1)-1:0] q_count,
  output logic [ADDR_W-1:0]          id_pc,
  output logic [INST_W-1:0]          id_inst,
  output logic                       id_valid
`ifdef IFQ_OCC_MAX_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occ_max
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = ADDR_W + INST_W;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              full_q, full_d;
  logic [ADDR_W-1:0] id_pc_q, id_pc_d;
  logic [INST_W-1:0] id_inst_q, id_inst_d;
  logic              id_valid_q, id_valid_d;

  logic              push;
  logic              wr_en;
  logic              pop;
  logic [ENT_W-1:0]  head;

  // Only two bits of the controller vector concern this stage.
  logic unused_stall_bits;
  assign unused_stall_bits = ^stall;

  ifq_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata ({if_pc, if_inst}),
    .raddr (rd_ptr_q),
    .rdata (head)
  );

  always_comb begin
    // Registered full flag gates the push; a same-cycle pop does not make room.
    push       = if_valid && !full_q && !flush;
    wr_en      = 1'b0;
    pop        = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    full_d     = full_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      cnt_d      = '0;
      full_d     = 1'b0;
      id_pc_d    = ADDR_W'(ZeroWord);
      id_inst_d  = INST_W'(ZeroWord);
      id_valid_d = 1'b0;
    end else begin
      if (stall[STAGE] == Stop) begin
        // Stage frozen: IF may still deposit into the queue.
        wr_en = push;
        if (stall[STAGE+1] == NoStop) begin
          id_pc_d    = ADDR_W'(ZeroWord);
          id_inst_d  = INST_W'(ZeroWord);
          id_valid_d = 1'b0;
        end
      end else if (cnt_q != '0) begin
        // Oldest entry first; a push joins the tail behind it.
        pop        = 1'b1;
        wr_en      = push;
        id_pc_d    = head[ENT_W-1:INST_W];
        id_inst_d  = head[INST_W-1:0];
        id_valid_d = 1'b1;
      end else if (push) begin
        // Empty queue: straight into the output register, array untouched.
        id_pc_d    = if_pc;
        id_inst_d  = if_inst;
        id_valid_d = 1'b1;
      end else begin
        id_pc_d    = ADDR_W'(ZeroWord);
        id_inst_d  = INST_W'(ZeroWord);
        id_valid_d = 1'b0;
      end

      // Pointer width equals log2(DEPTH), so the increment wraps modulo DEPTH.
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
      cnt_d  = cnt_q + CNT_W'(wr_en) - CNT_W'(pop);
      full_d = (cnt_d == CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      full_q     <= 1'b0;
      id_pc_q    <= ADDR_W'(ZeroWord);
      id_inst_q  <= INST_W'(ZeroWord);
      id_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      full_q     <= full_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
    end
  end

`ifdef IFQ_OCC_MAX_EN
  // High-water mark of occupancy; survives flush, cleared only by reset.
  logic [CNT_W-1:0] occ_max_q, occ_max_d;

  always_comb begin
    occ_max_d = (cnt_d > occ_max_q) ? cnt_d : occ_max_q;
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      occ_max_q <= '0;
    end else begin
      occ_max_q <= occ_max_d;
    end
  end

  assign occ_max = occ_max_q;
`endif

  assign if_full  = full_q;
  assign q_count  = cnt_q;
  assign id_pc    = id_pc_q;
  assign id_inst  = id_inst_q;
  assign id_valid = id_valid_q;

endmodule : if_id_queue
